// File: rtl/viol_reset_ctrl.sv
// Purpose: responder for access-monitor reset requests; logs the first violation and drives sys_rst.
// Latency: sys_rst rises 1 cycle after a request; held >= HOLD_CYCLES+1 cycles, until the reset vector is fetched.
// Backpressure: none; requests arriving during an episode merge into the cause vector; reads are combinational.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   viol_req[NSRC]      level requests from the monitors
//   pc, data_addr       current CPU fetch / data addresses (captured into the log)
//   per_addr/en/we/din  peripheral bus access to the 4-word log window
//   per_dout            peripheral read data (0 unless a secure-ROM read hits the window)
//   sys_rst             system reset request, active-high
//   rst_ack             one-cycle pulse when an episode ends
module viol_reset_ctrl #(
    parameter int          NSRC          = 3,
    parameter logic [15:0] HOLD_CYCLES   = 16'd8,
    parameter logic [15:0] RESET_HANDLER = 16'hFFFE,
    parameter logic [15:0] SMEM_BASE     = 16'hA000,
    parameter logic [15:0] SMEM_SIZE     = 16'h4000,
    parameter logic [15:0] LOG_BASE      = 16'h0190,
    parameter logic [7:0]  CLR_KEY       = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NSRC-1:0]  viol_req,
    input  logic [15:0]      pc,
    input  logic [15:0]      data_addr,
    input  logic [15:0]      per_addr,
    input  logic             per_en,
    input  logic [1:0]       per_we,
    input  logic [15:0]      per_din,
    output logic [15:0]      per_dout,
    output logic             sys_rst,
    output logic             rst_ack
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_HOLD     = 2'd1;
    localparam logic [1:0] S_WAIT_VEC = 2'd2;

    // Last word-aligned address inside secure ROM.
    localparam logic [15:0] SMEM_LAST = SMEM_BASE + SMEM_SIZE - 16'd2;

    logic [1:0]  state;
    logic [15:0] hold_cnt;
    logic [7:0]  cause;
    logic [7:0]  viol_cnt;
    logic [15:0] log_pc;
    logic [15:0] log_daddr;

    logic [7:0]  req8;
    logic        any_req;
    logic        in_srom;
    logic [15:0] win_off;
    logic        in_win;
    logic [1:0]  win_sel;
    logic        clr_hit;

    // Byte lane 0 of write data and the address LSB carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{per_addr[0], per_din[7:0]};

    always_comb begin
        req8 = 8'h00;
        req8[NSRC-1:0] = viol_req;
    end

    assign any_req = |viol_req;
    assign in_srom = (pc >= SMEM_BASE) && (pc <= SMEM_LAST);

    // Offset into the log window; wraps large for addresses below LOG_BASE.
    assign win_off = {per_addr[15:1], 1'b0} - LOG_BASE;
    assign in_win  = (win_off < 16'd8);
    assign win_sel = win_off[2:1];

    assign clr_hit = per_en && (per_we == 2'b11) && in_win && (win_sel == 2'd0)
                     && (per_din[15:8] == CLR_KEY) && in_srom;

    always_comb begin
        per_dout = 16'h0000;
        if (per_en && (per_we == 2'b00) && in_win && in_srom) begin
            case (win_sel)
                2'd0:    per_dout = {viol_cnt, cause};
                2'd1:    per_dout = log_pc;
                2'd2:    per_dout = log_daddr;
                default: per_dout = {14'b0, state};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            hold_cnt  <= 16'h0000;
            sys_rst   <= 1'b0;
            rst_ack   <= 1'b0;
            cause     <= 8'h00;
            viol_cnt  <= 8'h00;
            log_pc    <= 16'h0000;
            log_daddr <= 16'h0000;
        end else begin
            rst_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Capture takes precedence over a coincident software clear.
                    if (any_req) begin
                        cause     <= req8;
                        log_pc    <= pc;
                        log_daddr <= data_addr;
                        if (viol_cnt != 8'hFF) begin
                            viol_cnt <= viol_cnt + 8'd1;
                        end
                        hold_cnt  <= HOLD_CYCLES - 16'd1;
                        sys_rst   <= 1'b1;
                        state     <= S_HOLD;
                    end else if (clr_hit) begin
                        cause     <= 8'h00;
                        viol_cnt  <= 8'h00;
                        log_pc    <= 16'h0000;
                        log_daddr <= 16'h0000;
                    end
                end
                S_HOLD: begin
                    // Later requests only add cause bits; the first violation owns pc/daddr.
                    cause <= cause | req8;
                    if (hold_cnt == 16'h0000) begin
                        state <= S_WAIT_VEC;
                    end else begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end
                end
                S_WAIT_VEC: begin
                    // A still-asserted request keeps the system in reset.
                    if (any_req) begin
                        cause <= cause | req8;
                    end else if (pc == RESET_HANDLER) begin
                        state   <= S_IDLE;
                        sys_rst <= 1'b0;
                        rst_ack <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    sys_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_viol_reset_ctrl.sv
// Purpose: self-checking bench for viol_reset_ctrl (directed scenarios plus randomized traffic).
// Latency: checks outputs 1 time unit after each rising edge; reads checked combinationally.
// Backpressure: not applicable.
module tb_viol_reset_ctrl;

    localparam int HOLD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  viol_req = 3'b000;
    logic [15:0] pc = 16'h0000;
    logic [15:0] data_addr = 16'h0000;
    logic [15:0] per_addr = 16'h0000;
    logic        per_en = 1'b0;
    logic [1:0]  per_we = 2'b00;
    logic [15:0] per_din = 16'h0000;
    logic [15:0] per_dout;
    logic        sys_rst;
    logic        rst_ack;

    int errors = 0;
    int checks = 0;

    // Reference model: an episode is "active" with an age counting edges since capture.
    bit          m_active;
    int          m_age;
    logic [7:0]  m_cause;
    int          m_cnt;
    logic [15:0] m_pc;
    logic [15:0] m_daddr;
    bit          m_ack;

    viol_reset_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .viol_req  (viol_req),
        .pc        (pc),
        .data_addr (data_addr),
        .per_addr  (per_addr),
        .per_en    (per_en),
        .per_we    (per_we),
        .per_din   (per_din),
        .per_dout  (per_dout),
        .sys_rst   (sys_rst),
        .rst_ack   (rst_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_active = 0; m_age = 0; m_cause = 8'h00; m_cnt = 0;
        m_pc = 16'h0000; m_daddr = 16'h0000; m_ack = 0;
    endtask

    function automatic bit pc_secure(input logic [15:0] p);
        return (p >= 16'hA000) && (p <= 16'hDFFE);
    endfunction

    // One clock edge of the specified behaviour, using the inputs present at the edge.
    task automatic m_step();
        logic [7:0] r;
        r = {5'b0, viol_req};
        m_ack = 0;
        if (m_active) begin
            if (m_age >= HOLD && r == 8'h00 && pc == 16'hFFFE) begin
                m_active = 0;
                m_ack = 1;
            end else begin
                m_cause = m_cause | r;
                m_age++;
            end
        end else if (r != 8'h00) begin
            m_active = 1; m_age = 0; m_cause = r; m_pc = pc; m_daddr = data_addr;
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
        end else if (per_en && per_we == 2'b11 && {per_addr[15:1], 1'b0} == 16'h0190
                     && per_din[15:8] == 8'hA5 && pc_secure(pc)) begin
            m_cause = 8'h00; m_cnt = 0; m_pc = 16'h0000; m_daddr = 16'h0000;
        end
    endtask

    function automatic logic [15:0] exp_rd();
        int off;
        int st;
        off = int'({per_addr[15:1], 1'b0}) - 16'h0190;
        st = !m_active ? 0 : (m_age < HOLD ? 1 : 2);
        if (!per_en || per_we != 2'b00 || off < 0 || off > 7 || !pc_secure(pc)) return 16'h0000;
        case (off / 2)
            0: return {8'(m_cnt), m_cause};
            1: return m_pc;
            2: return m_daddr;
            default: return 16'(st);
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
        chk("sys_rst", {15'b0, sys_rst}, {15'b0, m_active});
        chk("rst_ack", {15'b0, rst_ack}, {15'b0, m_ack});
    endtask

    task automatic rd(input string tag, input logic [15:0] off, input logic [15:0] pcv);
        per_en = 1'b1; per_we = 2'b00; per_addr = 16'h0190 + off; pc = pcv;
        #1;
        chk(tag, per_dout, exp_rd());
    endtask

    task automatic wr_status(input logic [15:0] din, input logic [15:0] pcv);
        per_en = 1'b1; per_we = 2'b11; per_addr = 16'h0190; per_din = din; pc = pcv;
        cyc();
        per_en = 1'b0; per_we = 2'b00;
    endtask

    // Single-cycle request, hold pc off the vector, then fetch the vector.
    task automatic episode(input logic [2:0] req, input int wait_cycles);
        viol_req = req; pc = 16'h1234;
        cyc();
        viol_req = 3'b000;
        for (int i = 0; i < wait_cycles; i++) cyc();
        pc = 16'hFFFE;
        cyc();
    endtask

    initial begin
        int n;
        m_reset();
        #12 rst_n = 1'b1;
        #1;
        chk("reset_sys_rst", {15'b0, sys_rst}, 16'h0000);
        chk("reset_rst_ack", {15'b0, rst_ack}, 16'h0000);
        chk("reset_dout_idle", per_dout, 16'h0000);
        rd("reset_status", 16'd0, 16'hA010);
        rd("reset_state", 16'd6, 16'hA010);
        per_en = 1'b0;

        // Single violation.
        @(posedge clk); #1;
        viol_req = 3'b010; pc = 16'h4410; data_addr = 16'h0500;
        cyc();
        chk("single_rise", {15'b0, sys_rst}, 16'h0001);
        viol_req = 3'b000; pc = 16'h4412; data_addr = 16'h0000;
        for (int i = 0; i < 10; i++) cyc();
        chk("single_still_high", {15'b0, sys_rst}, 16'h0001);
        pc = 16'hFFFE;
        cyc();
        chk("single_ack", {15'b0, rst_ack}, 16'h0001);
        cyc();
        chk("single_ack_once", {15'b0, rst_ack}, 16'h0000);
        rd("single_status", 16'd0, 16'hA010);
        chk("single_status_k", per_dout, 16'h0102);
        rd("single_pc", 16'd2, 16'hA010);
        chk("single_pc_k", per_dout, 16'h4410);
        rd("single_daddr", 16'd4, 16'hA010);
        chk("single_daddr_k", per_dout, 16'h0500);
        per_en = 1'b0;

        // Early vector fetch while the hold counter is still at 3.
        viol_req = 3'b100; pc = 16'h0000;
        cyc();
        viol_req = 3'b000;
        for (int i = 0; i < 4; i++) cyc();
        pc = 16'hFFFE;
        n = 0;
        for (int i = 0; i < 20 && !rst_ack; i++) begin
            cyc();
            n++;
        end
        chk("early_exit_cycle", 16'(n), 16'd5);

        // Read/clear protection.
        rd("prot_nonsrom_read", 16'd0, 16'hE000);
        chk("prot_nonsrom_k", per_dout, 16'h0000);
        wr_status(16'hA500, 16'h4000);
        rd("prot_nonsrom_clr", 16'd0, 16'hA010);
        chk("prot_nonsrom_clr_k", per_dout, 16'h0204);
        wr_status(16'h5A00, 16'hA100);
        rd("prot_badkey", 16'd0, 16'hA010);
        chk("prot_badkey_k", per_dout, 16'h0204);
        wr_status(16'hA500, 16'hA100);
        for (int a = 0; a < 3; a++) begin
            rd("prot_cleared", 16'(2 * a), 16'hA010);
            chk("prot_cleared_k", per_dout, 16'h0000);
        end
        per_en = 1'b0;

        // Late request merges and blocks exit.
        viol_req = 3'b001; pc = 16'h0000;
        cyc();
        viol_req = 3'b000;
        cyc(); cyc();
        viol_req = 3'b100; pc = 16'hFFFE;
        for (int i = 0; i < 10; i++) cyc();
        chk("merge_blocked", {15'b0, sys_rst}, 16'h0001);
        viol_req = 3'b000;
        cyc();
        chk("merge_exit", {15'b0, rst_ack}, 16'h0001);
        rd("merge_status", 16'd0, 16'hA010);
        chk("merge_status_k", per_dout, 16'h0105);
        per_en = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            viol_req = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            case ($urandom_range(0, 3))
                0: pc = 16'hFFFE;
                1: pc = 16'($urandom_range(16'hA000, 16'hDFFF));
                2: pc = 16'hE000;
                default: pc = 16'($urandom);
            endcase
            data_addr = 16'($urandom);
            per_en   = 1'($urandom_range(0, 1));
            per_we   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            per_addr = 16'h018C + 16'($urandom_range(0, 14));
            per_din  = {($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom), 8'($urandom)};
            #1;
            chk("rand_dout", per_dout, exp_rd());
            cyc();
        end
        viol_req = 3'b000; per_en = 1'b0; per_we = 2'b00; pc = 16'hFFFE;
        for (int i = 0; i < 20; i++) cyc();

        // Counter saturation.
        for (int e = 0; e < 260; e++) episode(3'b001, HOLD);
        rd("sat_status", 16'd0, 16'hA010);
        chk("sat_cnt", {8'h00, per_dout[15:8]}, 16'h00FF);
        per_en = 1'b0;
        episode(3'b010, HOLD);
        rd("sat_stays", 16'd0, 16'hA010);
        chk("sat_stays_k", {8'h00, per_dout[15:8]}, 16'h00FF);
        per_en = 1'b0;

        // Async reset in the middle of HOLD.
        viol_req = 3'b011; pc = 16'h0000;
        cyc();
        viol_req = 3'b000;
        cyc(); cyc();
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst_sys_rst", {15'b0, sys_rst}, 16'h0000);
        chk("arst_rst_ack", {15'b0, rst_ack}, 16'h0000);
        #4 rst_n = 1'b1;
        rd("arst_state", 16'd6, 16'hA010);
        chk("arst_state_k", per_dout, 16'h0000);
        rd("arst_status", 16'd0, 16'hA010);
        chk("arst_status_k", per_dout, 16'h0000);
        per_en = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/viol_reset_ctrl.md
Name: viol_reset_ctrl

Overview:
- Responder side of the access-monitor reset request. Collects violation requests from one or more monitors.
- On any request it captures a violation record: cause vector, PC, data address and a saturating count.
- It then drives the system reset request through a guaranteed minimum hold, and keeps it asserted until the CPU fetches the reset vector.
- The record is exposed read-only on the peripheral bus, readable only by code executing in secure ROM.

Parameters:
- NSRC, 3, number of violation request sources (1..8).
- HOLD_CYCLES, 16'd8, minimum cycles sys_rst stays asserted after capture (>=1).
- RESET_HANDLER, 16'hFFFE, PC value that ends the reset episode.
- SMEM_BASE, 16'hA000, secure ROM base.
- SMEM_SIZE, 16'h4000, secure ROM size in bytes.
- LOG_BASE, 16'h0190, peripheral base of the 4-word log window.
- CLR_KEY, 8'hA5, high byte required to clear the log.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- viol_req  in  NSRC  per-source reset requests, level, from monitors.
- pc  in  16  current program counter.
- data_addr  in  16  current data address.
- per_addr  in  16  peripheral byte address.
- per_en  in  1  peripheral access strobe.
- per_we  in  2  byte write enables; 0 means read.
- per_din  in  16  peripheral write data.
- per_dout  out  16  peripheral read data.
- sys_rst  out  1  system reset request, active-high.
- rst_ack  out  1  one-cycle pulse when an episode ends.

Behaviour:
- Async reset (rst_n=0) values:
  - state=IDLE, sys_rst=0, rst_ack=0, hold counter=0.
  - cause=0, log_pc=0, log_daddr=0, viol_cnt=0.
  - per_dout=0.
- "in_srom" is SMEM_BASE <= pc <= SMEM_BASE+SMEM_SIZE-2. Sums are 16-bit; this parameterisation does not overflow.
- FSM states: IDLE, HOLD, WAIT_VEC.
- IDLE, when |viol_req is high on a clock edge:
  - Capture cause=viol_req (zero-extended to 8 bits), log_pc=pc, log_daddr=data_addr.
  - viol_cnt increments by 1, saturating at 8'hFF.
  - Load hold counter with HOLD_CYCLES-1; go to HOLD.
  - sys_rst=1 from the next cycle, i.e. 1-cycle latency.
- HOLD:
  - sys_rst=1; counter decrements each cycle.
  - At counter==0, go to WAIT_VEC.
  - New requests in HOLD are OR-ed into cause. pc, daddr and count are not updated (first violation wins).
- WAIT_VEC:
  - sys_rst=1.
  - When pc==RESET_HANDLER and viol_req==0, go to IDLE, sys_rst=0 and pulse rst_ack for exactly 1 cycle, all on the same edge.
  - If viol_req!=0, stay and OR it into cause.
- sys_rst is therefore high for at least HOLD_CYCLES+1 cycles per episode.
- A request in the same cycle as the IDLE return is not lost. It is seen in IDLE on the next edge and starts a new episode, incrementing viol_cnt.
- The log survives episodes. It is cleared only by rst_n or by a software clear.
- Register window, word-aligned; per_addr[0] is ignored:
  - LOG_BASE+0 STATUS: {viol_cnt[7:0], cause[7:0]}.
  - LOG_BASE+2 LOG_PC.
  - LOG_BASE+4 LOG_DADDR.
  - LOG_BASE+6 STATE: {14'b0, state[1:0]}, with IDLE=0, HOLD=1, WAIT_VEC=2.
- Read (per_en=1, per_we=0, address in window):
  - per_dout is combinational with the register value if in_srom, else 0.
  - Outside the window or with per_en=0, per_dout=0.
- Clear:
  - Write with per_we=2'b11 to STATUS, per_din[15:8]==CLR_KEY, in_srom=1, state==IDLE.
  - Zeroes cause, viol_cnt, log_pc and log_daddr on the next edge.
- Any other write is ignored. This covers a wrong key, a partial byte write, non-SROM code, a non-IDLE state, and other offsets.
- A clear coinciding with a new request in IDLE: capture wins. Result is a fresh record with viol_cnt=1 when the old count was cleared, and capture takes precedence over the clear.
- Reset mid-episode (rst_n low in any state): immediate return to IDLE with all outputs at reset values.

Test Plan:
- Single violation:
  - Stimulus: NSRC=3, IDLE, viol_req=3'b010 one cycle with pc=16'h4410, data_addr=16'h0500; hold pc=16'h4412; then pc=16'hFFFE.
  - Required: sys_rst rises next cycle, stays high 9+ cycles until the pc=FFFE edge, rst_ack pulses once.
  - Required: STATUS read from pc=16'hA010 returns 16'h0102, LOG_PC=16'h4410, LOG_DADDR=16'h0500.
- Early vector:
  - Stimulus: pc=16'hFFFE while in HOLD (counter=3).
  - Required: sys_rst remains high; exit occurs only in WAIT_VEC with pc=FFFE.
- Late request merges:
  - Stimulus: viol_req=3'b001 in IDLE, then 3'b100 during HOLD and held into WAIT_VEC with pc=FFFE.
  - Required: no exit while request high; cause=8'h05; viol_cnt=1; exit on the first edge with request low and pc=FFFE.
- Read/clear protection:
  - Non-SROM read of STATUS (pc=16'hE000) returns 0.
  - Clear from pc=16'h4000 with per_din=16'hA500 is ignored.
  - From pc=16'hA100, per_din=16'h5A00 is ignored; 16'hA500 zeroes all log registers.
- Counter saturation:
  - Stimulus: 260 episodes, each a 1-cycle request, then waiting for pc=FFFE.
  - Required: viol_cnt reads 8'hFF and stays there.
- Async reset mid-HOLD:
  - Stimulus: rst_n low for half a cycle.
  - Required: sys_rst=0 immediately, STATE reads 0 and STATUS reads 0 after release.
